decoder_pulse: RTL

//  Parametrised, registered one-hot decoder with valid/ready input handshake.

---
 rtl/decoder_pkg.sv | 15 +
 rtl/onehot_dec.sv | 21 ++
 rtl/decoder_pulse.sv | 134 +++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and state type for the registered one-hot decoder.
package decoder_pkg;

  localparam int unsigned MODE_LEVEL = 0;
  localparam int unsigned MODE_PULSE = 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_PULSE = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StPulse = ST_PULSE
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index-to-one-hot decoder with an in-range flag.
module onehot_dec #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 4
) (
  input  logic [IN_W-1:0]  in_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] onehot_o,
  output logic             in_range_o
);

  // Widen before comparing so OUT_W == 2**IN_W cannot truncate.
  always_comb begin
    in_range_o = (32'(in_i) < OUT_W);
    onehot_o   = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      onehot_o[i] = en_i && (32'(in_i) == i);
    end
  end

endmodule

// File: rtl/decoder_pulse.sv
// Registered one-hot decoder with valid/ready input, level or pulse output mode,
// and sticky out-of-range error flag.
module decoder_pulse
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W      = 2,
  parameter int unsigned OUT_W     = 4,
  parameter int unsigned MODE      = 0,
  parameter int unsigned PULSE_LEN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_i,
  input  logic             en_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [OUT_W-1:0] out_o,
  output logic             busy_o,
  output logic             err_o,
  input  logic             err_clr_i
);

  logic [OUT_W-1:0] onehot;
  logic             in_range;
  logic             accept;
  logic             hit;
  logic             bad;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q, err_d;

  onehot_dec #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_dec (
    .in_i      (in_i),
    .en_i      (en_i),
    .onehot_o  (onehot),
    .in_range_o(in_range)
  );

  assign accept = valid_i & ready_o;
  assign hit    = en_i & in_range;
  assign bad    = accept & en_i & ~in_range;

  // Set has priority over a same-cycle clear.
  always_comb begin
    err_d = err_q;
    if (bad) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
  assign out_o = out_q;

  if (MODE == MODE_LEVEL) begin : g_level
    assign ready_o = 1'b1;
    assign busy_o  = 1'b0;

    always_comb begin
      out_d = out_q;
      if (accept) begin
        out_d = onehot;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else begin
        out_q <= out_d;
      end
    end
  end else begin : g_pulse
    localparam int unsigned CntW = $clog2(PULSE_LEN + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign ready_o = (state_q == StIdle);
    assign busy_o  = (state_q == StPulse);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      unique case (state_q)
        StIdle: begin
          if (accept && hit) begin
            out_d   = onehot;
            cnt_d   = CntW'(PULSE_LEN - 1);
            state_d = StPulse;
          end
        end
        StPulse: begin
          // Counter holds the remaining high cycles after the current one.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            out_d   = '0;
            state_d = StIdle;
          end
        end
        default: begin
          out_d   = '0;
          state_d = StIdle;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        out_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
      end
    end
  end

endmodule
